reg_wb_queue: RTL and testbench

//  Write-back queue directly upstream of reg_file's single write port.

---
 rtl/reg_wb_queue_pkg.sv | 11 +
 rtl/wb_fifo.sv | 85 ++++++++
 rtl/reg_wb_queue.sv | 120 ++++++++++++
 tb/tb_reg_wb_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_queue_pkg.sv
// Shared definitions for the register write-back queue.
// RF_* widths match the downstream reg_file write port. PREF_* encode which
// producer wins the next contest for the last free FIFO slot.
package reg_wb_queue_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;

  localparam logic PREF_A = 1'b0;
  localparam logic PREF_B = 1'b1;
endpackage

// File: rtl/wb_fifo.sv
// In-order write FIFO, DEPTH x {addr,data}.
// Up to two pushes per cycle (A lands ahead of B) and one pop per cycle.
// Ports:
//   push_a_i/a_addr_i/a_data_i  first push of the cycle
//   push_b_i/b_addr_i/b_data_i  second push of the cycle
//   pop_i                       remove head (caller guarantees non-empty)
//   head_addr_o/head_data_o     current head entry
//   count_o                     occupied entries
//   ent_vld_o/ent_addr_o        per-slot valid + addr, used for hazard compare
module wb_fifo
  import reg_wb_queue_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_a_i,
  input  logic [ADDR_W-1:0]                a_addr_i,
  input  logic [DATA_W-1:0]                a_data_i,
  input  logic                             push_b_i,
  input  logic [ADDR_W-1:0]                b_addr_i,
  input  logic [DATA_W-1:0]                b_data_i,
  input  logic                             pop_i,
  output logic [ADDR_W-1:0]                head_addr_o,
  output logic [DATA_W-1:0]                head_data_o,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic [DEPTH-1:0]                 ent_vld_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]     ent_addr_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, b_slot;
  logic [CNT_W-1:0]             count_q, count_d;

  // B goes into the slot after A when both push together.
  assign b_slot = wr_ptr_q + PTR_W'(push_a_i);

  always_comb begin
    vld_d = vld_q;
    if (pop_i)    vld_d[rd_ptr_q] = 1'b0;
    if (push_a_i) vld_d[wr_ptr_q] = 1'b1;
    if (push_b_i) vld_d[b_slot]   = 1'b1;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; slot valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push_a_i) begin
      addr_q[wr_ptr_q] <= a_addr_i;
      data_q[wr_ptr_q] <= a_data_i;
    end
    if (push_b_i) begin
      addr_q[b_slot] <= b_addr_i;
      data_q[b_slot] <= b_data_i;
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign count_o     = count_q;
  assign ent_vld_o   = vld_q;
  assign ent_addr_o  = addr_q;
endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the reg_file write port.
// Merges producer A (ALU) and B (load unit) over valid/ready, buffers writes
// in order, drains one per cycle onto registered rf_we/rf_waddr/rf_wdata and
// reports pending-write hazards for two operand-stage read addresses.
// Ports:
//   a_*/b_*            producer handshakes (addr, data)
//   rf_hold            write port owned elsewhere this cycle: no drain
//   rf_we/waddr/wdata  registered write to reg_file
//   chk_addrN/busyN    combinational pending-write query
//   count/full/empty   FIFO occupancy (output register not counted)
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DEPTH   = 4,
  parameter bit DROP_X0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_data,
  input  logic                   rf_hold,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic [ADDR_W-1:0]      chk_addr1,
  input  logic [ADDR_W-1:0]      chk_addr2,
  output logic                   chk_busy1,
  output logic                   chk_busy2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                         pref_q, pref_d;
  logic                         rf_we_q;
  logic [ADDR_W-1:0]            rf_waddr_q, head_addr;
  logic [DATA_W-1:0]            rf_wdata_q, head_data;
  logic                         free_ge2, free_one, contest, push_a, push_b, pop;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;

  function automatic logic is_x0(input logic [ADDR_W-1:0] ad);
    return DROP_X0 && (ad == ADDR_W'(RF_ZERO_REG));
  endfunction

  // Credit comes from the registered count only; a pop this edge does not
  // free a slot for this edge's push.
  assign free_ge2 = (count <= CNT_W'(DEPTH - 2));
  assign free_one = (count == CNT_W'(DEPTH - 1));
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  always_comb begin
    a_ready = free_ge2;
    b_ready = free_ge2;
    if (free_one) begin
      a_ready = ~b_valid | (pref_q == PREF_A);
      b_ready = ~a_valid | (pref_q == PREF_B);
    end
    // Fairness: the loser of a last-slot contest wins the next one.
    contest = free_one & a_valid & b_valid;
    pref_d  = contest ? ~pref_q : pref_q;
  end

  // x0 writes complete the handshake but never occupy a slot.
  assign push_a = a_valid & a_ready & ~is_x0(a_addr);
  assign push_b = b_valid & b_ready & ~is_x0(b_addr);
  assign pop    = ~rf_hold & ~empty;

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst),
    .push_a_i(push_a), .a_addr_i(a_addr), .a_data_i(a_data),
    .push_b_i(push_b), .b_addr_i(b_addr), .b_data_i(b_data),
    .pop_i(pop),
    .head_addr_o(head_addr), .head_data_o(head_data),
    .count_o(count), .ent_vld_o(ent_vld), .ent_addr_o(ent_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref_q     <= PREF_A;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      pref_q  <= pref_d;
      rf_we_q <= pop;
      if (pop) begin
        rf_waddr_q <= head_addr;
        rf_wdata_q <= head_data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // A write stays pending until its rf_we cycle ends, so the output
  // register takes part in the compare alongside the queued entries.
  always_comb begin
    chk_busy1 = rf_we_q && (rf_waddr_q == chk_addr1);
    chk_busy2 = rf_we_q && (rf_waddr_q == chk_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == chk_addr1)) chk_busy1 = 1'b1;
      if (ent_vld[i] && (ent_addr[i] == chk_addr2)) chk_busy2 = 1'b1;
    end
    if (is_x0(chk_addr1)) chk_busy1 = 1'b0;
    if (is_x0(chk_addr2)) chk_busy2 = 1'b0;
  end
endmodule

// File: tb/tb_reg_wb_queue.sv
module tb_reg_wb_queue;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, a_ready, b_ready, rf_hold;
  logic [AW-1:0] a_addr, b_addr, chk_addr1, chk_addr2, rf_waddr;
  logic [DW-1:0] a_data, b_data, rf_wdata;
  logic          rf_we, chk_busy1, chk_busy2, full, empty;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  reg_wb_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .DROP_X0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .count(count), .full(full), .empty(empty)
  );

  // Downstream register file fed by the DUT write port.
  logic [DW-1:0] rf_arr [32];
  always @(posedge clk) if (rf_we) rf_arr[rf_waddr] <= rf_wdata;

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes plus the output register.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          mq[$];
  bit            m_prefb, m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic m_reset();
    mq.delete();
    m_prefb = 1'b0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  function automatic void m_rdy(output bit ar, output bit br);
    int free;
    free = DEPTH - mq.size();
    ar = (free >= 2) || (free == 1 && (!b_valid || !m_prefb));
    br = (free >= 2) || (free == 1 && (!a_valid || m_prefb));
  endfunction

  function automatic bit m_busy(input logic [AW-1:0] ad);
    if (ad == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == ad) return 1'b1;
    return m_we && (m_waddr == ad);
  endfunction

  task automatic m_step();
    bit ar, br, contest;
    ent_t e;
    m_rdy(ar, br);
    contest = (mq.size() == DEPTH - 1) && a_valid && b_valid;
    if (!rf_hold && mq.size() != 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (a_valid && ar && a_addr != 0) mq.push_back('{a: a_addr, d: a_data});
    if (b_valid && br && b_addr != 0) mq.push_back('{a: b_addr, d: b_data});
    if (contest) m_prefb = !m_prefb;
  endtask

  task automatic to_neg();
    bit ar, br;
    @(negedge clk);
    m_rdy(ar, br);
    check("m_a_ready", 64'(a_ready), 64'(ar));
    check("m_b_ready", 64'(b_ready), 64'(br));
    check("m_count", 64'(count), 64'(mq.size()));
    check("m_full", 64'(full), 64'(mq.size() == DEPTH));
    check("m_empty", 64'(empty), 64'(mq.size() == 0));
    check("m_rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      check("m_rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      check("m_rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    end
    check("m_busy1", 64'(chk_busy1), 64'(m_busy(chk_addr1)));
    check("m_busy2", 64'(chk_busy2), 64'(m_busy(chk_addr2)));
  endtask

  task automatic to_pos();
    @(posedge clk);
    m_step();
    #1;
  endtask

  typedef struct {
    int av, aa, ad, bv, ba, bd, hold, c1;
    int ear, ebr, ecnt, ewe, ewa, ewd, eb1;
  } vec_t;
  vec_t tv[18];

  initial begin
    // av aa ad  bv ba bd  hold c1  ear ebr cnt  we wa wd  busy1
    tv[0]  = '{1,10,10,     0,0,0,        0,10, 1,1,0, 0,0,0,       0};
    tv[1]  = '{0,0,0,       0,0,0,        0,10, 1,1,1, 0,0,0,       1};
    tv[2]  = '{1,3,'h33,    1,4,'h44,     0,10, 1,1,0, 1,10,10,     1};
    tv[3]  = '{0,0,0,       0,0,0,        0,10, 1,1,2, 0,0,0,       0};
    tv[4]  = '{0,0,0,       0,0,0,        0,4,  1,1,1, 1,3,'h33,    1};
    tv[5]  = '{1,5,'h55,    1,6,'h66,     1,4,  1,1,0, 1,4,'h44,    1};
    tv[6]  = '{1,7,'h77,    1,8,'h88,     1,7,  1,1,2, 0,0,0,       0};
    tv[7]  = '{1,9,'h99,    1,11,'hbb,    1,7,  0,0,4, 0,0,0,       1};
    tv[8]  = '{1,9,'h99,    1,11,'hbb,    0,7,  0,0,4, 0,0,0,       1};
    tv[9]  = '{1,9,'h99,    1,11,'hbb,    0,7,  1,0,3, 1,5,'h55,    1};
    tv[10] = '{1,12,'hcc,   1,11,'hbb,    0,7,  0,1,3, 1,6,'h66,    1};
    tv[11] = '{1,0,'hff,    0,0,0,        1,7,  1,0,3, 1,7,'h77,    1};
    tv[12] = '{0,0,0,       0,0,0,        1,0,  1,1,3, 0,0,0,       0};
    tv[13] = '{0,0,0,       0,0,0,        0,8,  1,1,3, 0,0,0,       1};
    tv[14] = '{0,0,0,       0,0,0,        0,9,  1,1,2, 1,8,'h88,    1};
    tv[15] = '{0,0,0,       0,0,0,        0,8,  1,1,1, 1,9,'h99,    0};
    tv[16] = '{0,0,0,       0,0,0,        0,11, 1,1,0, 1,11,'hbb,   1};
    tv[17] = '{0,0,0,       0,0,0,        0,11, 1,1,0, 0,0,0,       0};

    rst = 1'b1; a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0;
    a_data = 0; b_data = 0; rf_hold = 0; chk_addr1 = 0; chk_addr2 = 4;
    m_reset();

    // Reset state
    @(negedge clk);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_a_ready", 64'(a_ready), 64'd1);
    check("rst_b_ready", 64'(b_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table: single, dual, fill, contest, x0 drop, hazard window
    for (int i = 0; i < 18; i++) begin
      a_valid = 1'(tv[i].av); a_addr = AW'(tv[i].aa); a_data = DW'(tv[i].ad);
      b_valid = 1'(tv[i].bv); b_addr = AW'(tv[i].ba); b_data = DW'(tv[i].bd);
      rf_hold = 1'(tv[i].hold); chk_addr1 = AW'(tv[i].c1);
      to_neg();
      check($sformatf("v%0d_a_ready", i), 64'(a_ready), 64'(tv[i].ear));
      check($sformatf("v%0d_b_ready", i), 64'(b_ready), 64'(tv[i].ebr));
      check($sformatf("v%0d_count", i), 64'(count), 64'(tv[i].ecnt));
      check($sformatf("v%0d_full", i), 64'(full), 64'(tv[i].ecnt == DEPTH));
      check($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(tv[i].ewe));
      if (tv[i].ewe != 0) begin
        check($sformatf("v%0d_waddr", i), 64'(rf_waddr), 64'(tv[i].ewa));
        check($sformatf("v%0d_wdata", i), 64'(rf_wdata), 64'(tv[i].ewd));
      end
      check($sformatf("v%0d_busy1", i), 64'(chk_busy1), 64'(tv[i].eb1));
      to_pos();
    end
    check("rf10", 64'(rf_arr[10]), 64'd10);
    check("rf3", 64'(rf_arr[3]), 64'h33);
    check("rf4", 64'(rf_arr[4]), 64'h44);
    check("rf8", 64'(rf_arr[8]), 64'h88);
    check("rf11", 64'(rf_arr[11]), 64'hbb);

    // Reset while a write is in flight and another is queued
    a_valid = 1; a_addr = 1; a_data = 'h11;
    b_valid = 1; b_addr = 2; b_data = 'h22; rf_hold = 0; chk_addr1 = 2;
    to_neg(); to_pos();
    a_valid = 0; b_valid = 0;
    to_neg(); to_pos();
    check("pre_rst_we", 64'(rf_we), 64'd1);
    check("pre_rst_count", 64'(count), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_we", 64'(rf_we), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_busy1", 64'(chk_busy1), 64'd0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the queue model
    for (int c = 0; c < 500; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_addr = AW'($urandom_range(0, 7));
      b_addr = AW'($urandom_range(0, 7));
      a_data = $urandom; b_data = $urandom;
      rf_hold = ($urandom_range(0, 9) < 4);
      chk_addr1 = AW'($urandom_range(0, 7));
      chk_addr2 = AW'($urandom_range(0, 7));
      to_neg();
      to_pos();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
